// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate encoder and the core's immediate
// decode path: immediate format encoding, base opcodes used by the loader,
// and the request record held in the encoder's first pipeline stage.
// No ports (package).
// ---------------------------------------------------------------------------
package imm_pkg;

  // Immediate format selector; must stay identical to the decode path.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;

  // Stage-1 request. The selector stays a raw 3-bit field because illegal
  // codes must travel down the pipe. Only imm[31:0] is kept: the range check
  // has already consumed the upper bits and no format packs above bit 31.
  typedef struct packed {
    logic [2:0]  imm_source;
    logic [31:0] imm;
    logic        err;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
  } enc_req_t;

endpackage

// File: rtl/imm_range_check.sv
// ---------------------------------------------------------------------------
// imm_range_check
// Combinational check that a 64-bit signed immediate fits the chosen
// instruction format and meets its alignment rule.
// Ports:
//   imm_source  in  3   format selector (imm_src_e encoding)
//   immediate   in  64  signed immediate / byte offset
//   err         out 1   immediate not representable or selector illegal
// ---------------------------------------------------------------------------
module imm_range_check
  import imm_pkg::*;
(
  input  logic [2:0]  imm_source,
  input  logic [63:0] immediate,
  output logic        err
);

  // A value fits in N signed bits when every bit from N-1 upward is a copy
  // of the sign, i.e. the upper slice is all ones or all zeros.
  logic fits_12;
  logic fits_13;
  logic fits_21;
  logic fits_32;

  assign fits_12 = (&immediate[63:11]) | ~(|immediate[63:11]);
  assign fits_13 = (&immediate[63:12]) | ~(|immediate[63:12]);
  assign fits_21 = (&immediate[63:20]) | ~(|immediate[63:20]);
  assign fits_32 = (&immediate[63:31]) | ~(|immediate[63:31]);

  // B and J offsets are halfword aligned; U only carries the upper 20 bits,
  // so the low 12 must already be zero.
  always_comb begin
    err = 1'b1;
    case (imm_src_e'(imm_source))
      IMM_I, IMM_S: err = ~fits_12;
      IMM_B:        err = ~fits_13 | immediate[0];
      IMM_J:        err = ~fits_21 | immediate[0];
      IMM_U:        err = ~fits_32 | (|immediate[11:0]);
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
// Two-stage pipelined RISC-V immediate encoder with valid/ready handshakes.
// S1 captures the request and its range/alignment verdict; S2 holds the
// packed instruction word until the consumer takes it.
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   in_valid, in_ready  request handshake
//   imm_source          format selector (000 I, 001 S, 010 B, 011 J, 100 U)
//   immediate           64-bit signed immediate
//   opcode, rd, rs1, rs2, funct3   instruction fields
//   out_valid, out_ready           result handshake
//   instr, out_err      encoded word and its error flag
//   err_count           saturating count of accepted erroneous words
// ---------------------------------------------------------------------------
module imm_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_source,
  input  logic [63:0]      immediate,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic             s1_valid;
  enc_req_t         s1_req;
  logic             s2_valid;
  logic [31:0]      s2_instr;
  logic             s2_err;
  logic [CNT_W-1:0] err_cnt;

  logic             range_err;
  logic             s1_advance;
  enc_req_t         next_req;
  logic [31:0]      packed_word;

  imm_range_check u_range_check (
    .imm_source (imm_source),
    .immediate  (immediate),
    .err        (range_err)
  );

  // S1 may move on whenever S2 is empty or being drained this cycle, which
  // lets the pipe stream one word per cycle without bubbles.
  assign s1_advance = ~s2_valid | out_ready;
  assign in_ready   = ~s1_valid | s1_advance;

  always_comb begin
    next_req            = '0;
    next_req.imm_source = imm_source;
    next_req.imm        = immediate[31:0];
    next_req.err        = range_err;
    next_req.opcode     = opcode;
    next_req.rd         = rd;
    next_req.rs1        = rs1;
    next_req.rs2        = rs2;
    next_req.funct3     = funct3;
  end

  // Field packing; on a range error the truncated bits are still packed so
  // the loader sees what the hardware would actually execute.
  always_comb begin
    packed_word = 32'h0;
    case (imm_src_e'(s1_req.imm_source))
      IMM_I: packed_word = {s1_req.imm[11:0], s1_req.rs1, s1_req.funct3,
                            s1_req.rd, s1_req.opcode};
      IMM_S: packed_word = {s1_req.imm[11:5], s1_req.rs2, s1_req.rs1,
                            s1_req.funct3, s1_req.imm[4:0], s1_req.opcode};
      IMM_B: packed_word = {s1_req.imm[12], s1_req.imm[10:5], s1_req.rs2,
                            s1_req.rs1, s1_req.funct3, s1_req.imm[4:1],
                            s1_req.imm[11], s1_req.opcode};
      IMM_J: packed_word = {s1_req.imm[20], s1_req.imm[10:1], s1_req.imm[11],
                            s1_req.imm[19:12], s1_req.rd, s1_req.opcode};
      IMM_U: packed_word = {s1_req.imm[31:12], s1_req.rd, s1_req.opcode};
      default: packed_word = 32'h0;
    endcase
  end

  // S1: load on an accepted request, otherwise empty out once S2 has taken
  // the held request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_req   <= next_req;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: the word only changes when S2 is free to advance, so a stalled
  // output stays stable until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_instr <= 32'h0;
      s2_err   <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= packed_word;
        s2_err   <= s1_req.err;
      end
    end
  end

  // Count erroneous words as they are handed over, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && s2_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign instr     = s2_instr;
  assign out_err   = s2_err;
  assign err_count = err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
// Self-checking bench for imm_encoder: directed scenarios plus randomized
// traffic with random backpressure, checked against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       imm_source;
  logic [63:0]      immediate;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          exp_errs = 0;
  int          acc_count = 0;
  logic        mon_en = 1'b0;
  logic        rand_ready = 1'b0;
  logic        held = 1'b0;
  logic [31:0] held_instr;
  logic        held_err;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_source (imm_source),
    .immediate  (immediate),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .out_err    (out_err),
    .err_count  (err_count)
  );

  // Rising edges at 5, 15, 25...; inputs change on falling edges and are
  // sampled 4 time units later, just before the next rising edge.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [63:0] fld(input logic [63:0] v, input int hi, input int lo);
    return (v >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  // Reference: legality from signed numeric ranges, packing by shifting
  // immediate bit-fields into their instruction positions.
  function automatic exp_t refEncode(input logic [2:0] src, input logic [63:0] imm,
                                     input logic [6:0] op, input logic [4:0] rd_v,
                                     input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                     input logic [2:0] f3);
    exp_t        e;
    longint      s;
    logic [63:0] w;
    logic [63:0] regs_i;
    s = longint'(imm);
    regs_i = (64'(rs1_v) << 15) | (64'(f3) << 12);
    e.err = 1'b1;
    w = 64'd0;
    case (src)
      3'd0: begin
        e.err = !(s >= -2048 && s <= 2047);
        w = (fld(imm, 11, 0) << 20) | regs_i | (64'(rd_v) << 7) | 64'(op);
      end
      3'd1: begin
        e.err = !(s >= -2048 && s <= 2047);
        w = (fld(imm, 11, 5) << 25) | (64'(rs2_v) << 20) | regs_i
          | (fld(imm, 4, 0) << 7) | 64'(op);
      end
      3'd2: begin
        e.err = !(s >= -4096 && s <= 4095 && (s % 2) == 0);
        w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (64'(rs2_v) << 20)
          | regs_i | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 64'(op);
      end
      3'd3: begin
        e.err = !(s >= -(64'sd1 << 20) && s < (64'sd1 << 20) && (s % 2) == 0);
        w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
          | (fld(imm, 19, 12) << 12) | (64'(rd_v) << 7) | 64'(op);
      end
      3'd4: begin
        e.err = !(s >= -(64'sd1 << 31) && s < (64'sd1 << 31) && (s % 4096) == 0);
        w = (fld(imm, 31, 12) << 12) | (64'(rd_v) << 7) | 64'(op);
      end
      default: begin
        e.err = 1'b1;
        w = 64'd0;
      end
    endcase
    e.instr = w[31:0];
    return e;
  endfunction

  // Drives one request and holds it until accepted; returns on the falling
  // edge after the accepting rising edge, with in_valid still high.
  task automatic applyStimulus(input logic [2:0] src, input logic [63:0] imm,
                               input logic [6:0] op, input logic [4:0] rd_v,
                               input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                               input logic [2:0] f3);
    int   waited;
    logic taken;
    imm_source = src;
    immediate  = imm;
    opcode     = op;
    rd         = rd_v;
    rs1        = rs1_v;
    rs2        = rs2_v;
    funct3     = f3;
    in_valid   = 1'b1;
    waited = 0;
    taken  = 1'b0;
    while (!taken && waited < 200) begin
      #4;
      taken = in_ready;
      @(negedge clk);
      waited++;
    end
    if (taken) begin
      sb.push_back(refEncode(src, imm, op, rd_v, rs1_v, rs2_v, f3));
      acc_count++;
    end else begin
      checkOutput("accept_timeout", 64'(taken), 64'd1);
    end
  endtask

  function automatic logic [63:0] randImm();
    longint v;
    longint b;
    int     k;
    case ($urandom_range(0, 3))
      0: begin
        v = longint'(int'($urandom_range(0, 10000)) - 5000);
        if ($urandom_range(0, 1) == 0) v = v & ~64'sd1;
      end
      1: begin
        case ($urandom_range(0, 3))
          0: k = 11;
          1: k = 12;
          2: k = 20;
          default: k = 31;
        endcase
        b = 64'sd1 << k;
        case ($urandom_range(0, 5))
          0: v = b - 1;
          1: v = b;
          2: v = -b;
          3: v = -b - 1;
          4: v = b - 2;
          default: v = -b + 2;
        endcase
      end
      2: v = longint'(signed'($urandom & 32'hFFFF_F000));
      default: v = longint'({$urandom, $urandom});
    endcase
    return 64'(v);
  endfunction

  // Random consumer backpressure while randomized traffic runs.
  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: scoreboard order, hold-stability under stall, counter.
  always begin
    exp_t e;
    int   exp_cnt;
    @(negedge clk);
    #4;
    if (rst) begin
      sb.delete();
      exp_errs = 0;
      held = 1'b0;
    end else if (mon_en) begin
      if (held) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_instr", 64'(instr), 64'(held_instr));
        checkOutput("hold_err", 64'(out_err), 64'(held_err));
      end
      exp_cnt = (exp_errs > CNT_MAX) ? CNT_MAX : exp_errs;
      checkOutput("err_count", 64'(err_count), 64'(exp_cnt));
      if (out_valid && out_ready) begin
        checkOutput("word_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("instr", 64'(instr), 64'(e.instr));
          checkOutput("out_err", 64'(out_err), 64'(e.err));
          if (e.err) exp_errs++;
        end
      end
      held       = out_valid && !out_ready;
      held_instr = instr;
      held_err   = out_err;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    imm_source = 3'd0;
    immediate = 64'd0;
    opcode = 7'd0;
    rd = 5'd0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    funct3 = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_err", 64'(out_err), 64'd0);
    checkOutput("rst_instr", 64'(instr), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // I-type with two-cycle latency.
    applyStimulus(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, OP_IMM, 5'd6, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    checkOutput("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_cycle2", 64'(out_valid), 64'd1);
    checkOutput("i_instr", 64'(instr), 64'h0000_0000_FFF0_0313);
    checkOutput("i_err", 64'(out_err), 64'd0);

    applyStimulus(3'd1, 64'd4, OP_STORE, 5'd0, 5'd2, 5'd15, 3'd2);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("s_instr", 64'(instr), 64'h0000_0000_00F1_2223);
    applyStimulus(3'd4, 64'h1234_5000, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("u_instr", 64'(instr), 64'h0000_0000_1234_52B7);
    repeat (2) @(negedge clk);

    // Error cases back-to-back.
    applyStimulus(3'd2, 64'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0);
    applyStimulus(3'd3, 64'h10_0000, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0);
    applyStimulus(3'd4, 64'h1234_5001, OP_LUI, 5'd3, 5'd0, 5'd0, 3'd0);
    applyStimulus(3'b101, 64'd8, OP_IMM, 5'd3, 5'd4, 5'd5, 3'd1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("err_count_4", 64'(err_count), 64'd4);

    // Backpressure: consumer stalls for 3 cycles under 4 back-to-back requests.
    acc_count = 0;
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(3'd0, 64'd100, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0);
        applyStimulus(3'd1, 64'hFFFF_FFFF_FFFF_FFF0, OP_STORE, 5'd0, 5'd3, 5'd4, 3'd2);
        applyStimulus(3'd2, 64'd2046, OP_BRANCH, 5'd0, 5'd5, 5'd6, 3'd1);
        applyStimulus(3'd3, 64'hFFFF_FFFF_FFF0_0000, OP_JAL, 5'd7, 5'd0, 5'd0, 3'd0);
      end
      begin
        repeat (3) @(negedge clk);
        checkOutput("bp_accepted", 64'(acc_count), 64'd2);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("bp_accepted_all", 64'(acc_count), 64'd4);
    checkOutput("bp_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    applyStimulus(3'd0, 64'd1, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0);
    applyStimulus(3'd2, 64'd5, OP_BRANCH, 5'd0, 5'd1, 5'd1, 3'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_err_count", 64'(err_count), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    applyStimulus(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, OP_IMM, 5'd6, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_instr", 64'(instr), 64'h0000_0000_FFF0_0313);
    checkOutput("post_rst_valid", 64'(out_valid), 64'd1);
    repeat (2) @(negedge clk);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      applyStimulus(($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)),
                    randImm(), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom));
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rand_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
